// File: rtl/sim_mem_arbiter.sv
// Round-robin bridge from NUM_CH valid/ready request channels to a word-indexed 64-bit simulation RAM.
// Define SIM_MEM_RANGE_CHECK_EN to flag and suppress accesses outside the RAM window.
module sim_mem_arbiter #(
    parameter int          NUM_CH    = 2,
    parameter int          LATENCY   = 1,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          IDX_W     = 28
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    req_valid,
    output logic [NUM_CH-1:0]    req_ready,
    input  logic [NUM_CH-1:0]    req_wen,
    input  logic [NUM_CH*64-1:0] req_addr,
    input  logic [NUM_CH*64-1:0] req_wdata,
    input  logic [NUM_CH*8-1:0]  req_wmask,
    output logic [NUM_CH-1:0]    resp_valid,
    output logic [63:0]          resp_data,
    output logic                 resp_err,
    output logic                 mem_en,
    output logic                 mem_wen,
    output logic [IDX_W-1:0]     mem_idx,
    output logic [63:0]          mem_wdata,
    output logic [63:0]          mem_wmask,
    input  logic [63:0]          mem_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  rr, rr_nxt, win, grant;
    logic [3:0]  cnt, cnt_nxt;
    logic        found, accept, range_err;
    logic        err_q;
    logic [63:0] hold;
    logic [63:0] offset;
    logic [3:0]  valid4;

    logic [63:0] ch_addr  [4];
    logic [63:0] ch_wdata [4];
    logic [7:0]  ch_wmask [4];
    logic        ch_wen   [4];

    // Unpack the flat channel buses; slots above NUM_CH read as zero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ch_addr[i]  = 64'd0;
            ch_wdata[i] = 64'd0;
            ch_wmask[i] = 8'd0;
            ch_wen[i]   = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            ch_addr[i]  = req_addr[i*64 +: 64];
            ch_wdata[i] = req_wdata[i*64 +: 64];
            ch_wmask[i] = req_wmask[i*8 +: 8];
            ch_wen[i]   = req_wen[i];
        end
    end

    assign valid4 = 4'(req_valid);

    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        win   = 2'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = int'(rr) + k;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!found && valid4[c[1:0]]) begin
                found = 1'b1;
                win   = c[1:0];
            end
        end
        rr_nxt = (win == 2'(NUM_CH - 1)) ? 2'd0 : win + 2'd1;
    end

    assign offset = ch_addr[win] - BASE_ADDR;

`ifdef SIM_MEM_RANGE_CHECK_EN
    assign range_err = (ch_addr[win] < BASE_ADDR) || ((offset >> (IDX_W + 3)) != 64'd0);
`else
    assign range_err = 1'b0;
`endif

    // Outputs are forced to their idle values while reset is held.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        req_ready  = '0;
        resp_valid = '0;
        resp_data  = 64'd0;
        resp_err   = 1'b0;
        mem_en     = 1'b0;
        mem_wen    = 1'b0;
        mem_idx    = '0;
        mem_wdata  = 64'd0;
        mem_wmask  = 64'd0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        accept = 1'b1;
                        for (int i = 0; i < NUM_CH; i++) req_ready[i] = (win == 2'(i));
                        mem_en    = !range_err;
                        mem_wen   = ch_wen[win] && !range_err;
                        mem_idx   = IDX_W'(offset >> 3);
                        mem_wdata = ch_wdata[win];
                        for (int b = 0; b < 8; b++) mem_wmask[b*8 +: 8] = {8{ch_wmask[win][b]}};
                        cnt_nxt   = 4'(LATENCY - 1);
                        state_nxt = (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt <= 4'd1) state_nxt = RESP;
                end
                RESP: begin
                    for (int i = 0; i < NUM_CH; i++) resp_valid[i] = (grant == 2'(i));
                    resp_data = hold;
                    resp_err  = err_q;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            rr    <= 2'd0;
            cnt   <= 4'd0;
            grant <= 2'd0;
            err_q <= 1'b0;
            hold  <= 64'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                rr    <= rr_nxt;
                grant <= win;
                err_q <= range_err;
                hold  <= (ch_wen[win] || range_err) ? 64'd0 : mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_sim_mem_arbiter.sv
// Bench for sim_mem_arbiter: a 2-channel LATENCY=4 instance and a 1-channel LATENCY=1 instance,
// each on a small behavioural RAM, with expected responses queued at accept and checked on resp_valid.
module tb_sim_mem_arbiter;
    localparam int          LAT_A = 4;
    localparam int          LAT_B = 1;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    typedef struct {
        int          ch;
        logic [63:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic [1:0]   a_valid = '0, a_wen = '0;
    logic [127:0] a_addr = '0, a_wdata = '0;
    logic [15:0]  a_wmask = '0;
    logic [1:0]   a_ready, a_rvalid;
    logic [63:0]  a_rdata, a_mwdata, a_mwmask, a_mrdata;
    logic         a_err, a_men, a_mwen;
    logic [27:0]  a_idx;

    logic [0:0]   b_valid = '0, b_wen = '0;
    logic [63:0]  b_addr = '0, b_wdata = '0;
    logic [7:0]   b_wmask = '0;
    logic [0:0]   b_ready, b_rvalid;
    logic [63:0]  b_rdata, b_mwdata, b_mwmask, b_mrdata;
    logic         b_err, b_men, b_mwen;
    logic [27:0]  b_idx;

    sim_mem_arbiter #(.NUM_CH(2), .LATENCY(LAT_A), .BASE_ADDR(BASE), .IDX_W(28)) dut_a (
        .clock(clock), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_wen(a_wen), .req_addr(a_addr),
        .req_wdata(a_wdata), .req_wmask(a_wmask),
        .resp_valid(a_rvalid), .resp_data(a_rdata), .resp_err(a_err),
        .mem_en(a_men), .mem_wen(a_mwen), .mem_idx(a_idx), .mem_wdata(a_mwdata),
        .mem_wmask(a_mwmask), .mem_rdata(a_mrdata)
    );

    sim_mem_arbiter #(.NUM_CH(1), .LATENCY(LAT_B), .BASE_ADDR(BASE), .IDX_W(28)) dut_b (
        .clock(clock), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_wen(b_wen), .req_addr(b_addr),
        .req_wdata(b_wdata), .req_wmask(b_wmask),
        .resp_valid(b_rvalid), .resp_data(b_rdata), .resp_err(b_err),
        .mem_en(b_men), .mem_wen(b_mwen), .mem_idx(b_idx), .mem_wdata(b_mwdata),
        .mem_wmask(b_mwmask), .mem_rdata(b_mrdata)
    );

    logic [63:0] ram_a [16];
    logic [63:0] ram_b [16];
    logic [63:0] mdl_a [16];
    logic [63:0] mdl_b [16];

    function automatic logic [63:0] init_val(input int i);
        if (i == 0) return 64'h1122_3344_5566_7788;
        if (i == 1) return 64'h0;
        return {32'hC0DE_0000, 32'(i)};
    endfunction

    assign a_mrdata = ram_a[a_idx[3:0]];
    assign b_mrdata = ram_b[b_idx[3:0]];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                ram_a[i] <= init_val(i);
                ram_b[i] <= init_val(i);
            end
        end else begin
            if (a_men && a_mwen) ram_a[a_idx[3:0]] <= (ram_a[a_idx[3:0]] & ~a_mwmask) | (a_mwdata & a_mwmask);
            if (b_men && b_mwen) ram_b[b_idx[3:0]] <= (ram_b[b_idx[3:0]] & ~b_mwmask) | (b_mwdata & b_mwmask);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reload_models();
        for (int i = 0; i < 16; i++) begin
            mdl_a[i] = init_val(i);
            mdl_b[i] = init_val(i);
        end
    endtask

    task automatic on_resp(input int sel, input logic [1:0] rv, input logic [63:0] data, input logic err);
        exp_t e;
        int   qs;
        qs = (sel == 0) ? q_a.size() : q_b.size();
        if (qs == 0) begin
            check($sformatf("spurious_resp_%0d", sel), 64'(rv), 64'd0);
            return;
        end
        if (sel == 0) e = q_a.pop_front();
        else          e = q_b.pop_front();
        check($sformatf("resp_ch_%0d", sel), 64'(rv), (e.ch == 0) ? 64'd1 : 64'd2);
        check($sformatf("resp_data_%0d", sel), data, e.data);
        check($sformatf("resp_err_%0d", sel), 64'(err), 64'(e.err));
        check($sformatf("resp_cycle_%0d", sel), 64'(cyc), 64'(e.due));
    endtask

    always @(negedge clock) if (!reset && a_rvalid !== 2'b00) on_resp(0, a_rvalid, a_rdata, a_err);
    always @(negedge clock) if (!reset && b_rvalid !== 1'b0)  on_resp(1, {1'b0, b_rvalid}, b_rdata, b_err);

    task automatic drive(input int sel, input int ch, input logic v, input logic wen,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wmask);
        if (sel == 0) begin
            a_valid[ch[0]]       = v;
            a_wen[ch[0]]         = wen;
            a_addr[ch*64 +: 64]  = addr;
            a_wdata[ch*64 +: 64] = wdata;
            a_wmask[ch*8 +: 8]   = wmask;
        end else begin
            b_valid = v;
            b_wen   = wen;
            b_addr  = addr;
            b_wdata = wdata;
            b_wmask = wmask;
        end
    endtask

    // One request on one channel: wait for its grant, check the RAM-side strobes, queue the response.
    task automatic issue(input int sel, input int ch, input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wmask);
        int          n;
        logic        rdy, eerr;
        logic [63:0] off, emask, edata;
        logic [27:0] eidx;
        exp_t        e;
        off  = addr - BASE;
        eidx = off[30:3];
        for (int b = 0; b < 8; b++) emask[b*8 +: 8] = {8{wmask[b]}};
`ifdef SIM_MEM_RANGE_CHECK_EN
        eerr = (addr < BASE) || (off[63:31] != 33'd0);
`else
        eerr = 1'b0;
`endif
        @(negedge clock);
        drive(sel, ch, 1'b1, wen, addr, wdata, wmask);
        #1;
        n   = 0;
        rdy = (sel == 0) ? a_ready[ch[0]] : b_ready[0];
        while (rdy !== 1'b1 && n < 40) begin
            @(negedge clock);
            #1;
            n++;
            rdy = (sel == 0) ? a_ready[ch[0]] : b_ready[0];
        end
        check($sformatf("grant_%0d_ch%0d", sel, ch), 64'(rdy), 64'd1);
        if (rdy !== 1'b1) begin
            drive(sel, ch, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
            return;
        end
        if (sel == 0) begin
            check("a_ready_onehot", 64'(a_ready), (ch == 0) ? 64'd1 : 64'd2);
            check("a_mem_en", 64'(a_men), 64'(!eerr));
            check("a_mem_wen", 64'(a_mwen), 64'(wen && !eerr));
            if (!eerr) begin
                check("a_mem_idx", 64'(a_idx), 64'(eidx));
                check("a_mem_wdata", a_mwdata, wdata);
                check("a_mem_wmask", a_mwmask, emask);
            end
            edata = (eerr || wen) ? 64'd0 : mdl_a[eidx[3:0]];
            if (wen && !eerr) mdl_a[eidx[3:0]] = (mdl_a[eidx[3:0]] & ~emask) | (wdata & emask);
            e = '{ch, edata, eerr, cyc + LAT_A};
            q_a.push_back(e);
        end else begin
            check("b_mem_en", 64'(b_men), 64'(!eerr));
            check("b_mem_wen", 64'(b_mwen), 64'(wen && !eerr));
            if (!eerr) begin
                check("b_mem_idx", 64'(b_idx), 64'(eidx));
                check("b_mem_wdata", b_mwdata, wdata);
                check("b_mem_wmask", b_mwmask, emask);
            end
            edata = (eerr || wen) ? 64'd0 : mdl_b[eidx[3:0]];
            if (wen && !eerr) mdl_b[eidx[3:0]] = (mdl_b[eidx[3:0]] & ~emask) | (wdata & emask);
            e = '{0, edata, eerr, cyc + LAT_B};
            q_b.push_back(e);
        end
        @(posedge clock);
        #1;
        drive(sel, ch, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
    endtask

    task automatic drain(input int sel);
        int n;
        n = 0;
        while (((sel == 0) ? q_a.size() : q_b.size()) != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        #2;
        check($sformatf("drain_%0d", sel), 64'((sel == 0) ? q_a.size() : q_b.size()), 64'd0);
    endtask

    initial begin
        int   n_acc, last, expch;
        exp_t e;
        reload_models();
        // Both channels request from reset; nothing may be granted while reset is held.
        drive(0, 0, 1'b1, 1'b0, BASE + 64'd16, 64'd0, 8'd0);
        drive(0, 1, 1'b1, 1'b0, BASE + 64'd24, 64'd0, 8'd0);
        repeat (3) @(negedge clock);
        #1;
        check("rst_a_req_ready", 64'(a_ready), 64'd0);
        check("rst_a_resp_valid", 64'(a_rvalid), 64'd0);
        check("rst_a_resp_data", a_rdata, 64'd0);
        check("rst_a_resp_err", 64'(a_err), 64'd0);
        check("rst_a_mem_en", 64'(a_men), 64'd0);
        check("rst_a_mem_wen", 64'(a_mwen), 64'd0);
        check("rst_a_mem_idx", 64'(a_idx), 64'd0);
        check("rst_a_mem_wdata", a_mwdata, 64'd0);
        check("rst_a_mem_wmask", a_mwmask, 64'd0);
        check("rst_b_resp_valid", 64'(b_rvalid), 64'd0);
        check("rst_b_mem_en", 64'(b_men), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        n_acc = 0;
        last  = 0;
        expch = 0;
        for (int k = 0; k < 40 && n_acc < 3; k++) begin
            #1;
            if (a_ready !== 2'b00) begin
                check("rr_grant", 64'(a_ready), (expch == 0) ? 64'd1 : 64'd2);
                if (n_acc > 0) check("rr_spacing", 64'(cyc - last), 64'(LAT_A + 1));
                check("rr_mem_idx", 64'(a_idx), (expch == 0) ? 64'd2 : 64'd3);
                e = '{expch, mdl_a[(expch == 0) ? 2 : 3], 1'b0, cyc + LAT_A};
                q_a.push_back(e);
                last  = cyc;
                n_acc++;
                expch = 1 - expch;
            end
            @(negedge clock);
        end
        check("rr_accepts", 64'(n_acc), 64'd3);
        a_valid = 2'b00;
        drain(0);

        // Single channel, LATENCY=1: read, masked write, read back.
        issue(1, 0, 1'b0, BASE, 64'd0, 8'h00);
        issue(1, 0, 1'b1, BASE + 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        issue(1, 0, 1'b0, BASE + 64'd8, 64'd0, 8'h00);
        drain(1);
        check("b_readback_model", mdl_b[1], 64'h0000_0000_FFFF_FFFF);

        // Two channels, LATENCY=4.
        issue(0, 1, 1'b0, BASE, 64'd0, 8'h00);
        issue(0, 0, 1'b1, BASE + 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        issue(0, 1, 1'b0, BASE + 64'd8, 64'd0, 8'h00);
        issue(0, 0, 1'b1, BASE + 64'd32, 64'hDEAD_BEEF_0BAD_F00D, 8'hA5);
        issue(0, 1, 1'b0, BASE + 64'd32, 64'd0, 8'h00);
        drain(0);

        // Address window edges: just below base, one past the top, last valid word.
        issue(0, 0, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00);
        issue(0, 1, 1'b0, BASE + 64'h8000_0000, 64'd0, 8'h00);
        issue(0, 0, 1'b0, BASE + 64'h7FFF_FFF8, 64'd0, 8'h00);
        drain(0);

        // A channel that raises and drops valid while the bridge is busy gets nothing issued.
        issue(0, 0, 1'b0, BASE + 64'd16, 64'd0, 8'h00);
        drive(0, 1, 1'b1, 1'b0, BASE + 64'd40, 64'd0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            #1;
            check("busy_no_ready", 64'(a_ready), 64'd0);
            check("busy_no_mem_en", 64'(a_men), 64'd0);
        end
        drive(0, 1, 1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
        drain(0);

        // Reset while waiting: the pending response vanishes and arbitration restarts at ch0.
        issue(0, 0, 1'b0, BASE + 64'd16, 64'd0, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        void'(q_a.pop_back());
        @(negedge clock);
        reset = 1'b0;
        reload_models();
        repeat (8) @(negedge clock);
        check("reset_drop_queue", 64'(q_a.size()), 64'd0);
        drive(0, 0, 1'b1, 1'b0, BASE, 64'd0, 8'h00);
        drive(0, 1, 1'b1, 1'b0, BASE + 64'd24, 64'd0, 8'h00);
        #1;
        check("post_reset_rr", 64'(a_ready), 64'd1);
        if (a_ready === 2'b01) begin
            e = '{0, mdl_a[0], 1'b0, cyc + LAT_A};
            q_a.push_back(e);
            @(posedge clock);
            #1;
            drive(0, 0, 1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
        end else begin
            drive(0, 0, 1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
        end
        issue(0, 1, 1'b0, BASE + 64'd24, 64'd0, 8'h00);
        drain(0);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
